// File: rtl/ppu_pkg.sv
// Shared encodings and address map for the PPU video-memory slice:
// PPU mode codes, VRAM/OAM windows, the DMA trigger register and DMA FSM states.
package ppu_pkg;

  typedef enum logic [1:0] {
    PPU_HBLANK = 2'd0,
    PPU_VBLANK = 2'd1,
    PPU_SCAN   = 2'd2,
    PPU_DRAW   = 2'd3
  } PPU_STATES_t;

  typedef enum logic [1:0] {
    DMA_IDLE  = 2'd0,
    DMA_START = 2'd1,
    DMA_XFER  = 2'd2
  } dma_state_t;

  localparam logic [15:0] VRAM_BASE    = 16'h8000;
  localparam logic [15:0] VRAM_END     = 16'h9FFF;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam logic [15:0] OAM_END      = 16'hFE9F;
  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;

  function automatic logic is_vram(input logic [15:0] addr);
    return (addr >= VRAM_BASE) && (addr <= VRAM_END);
  endfunction

  function automatic logic is_oam(input logic [15:0] addr);
    return (addr >= OAM_BASE) && (addr <= OAM_END);
  endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// OAM DMA sequencer: START delay of one byte-period, then per byte a source read,
// a capture and one OAM write request. A trigger restarts it from any state.
module oam_dma_engine
  import ppu_pkg::*;
#(
  parameter int unsigned DMA_CYCLES_PER_BYTE = 4,
  parameter int unsigned DMA_LEN             = 160
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        trig_i,
  input  logic [7:0]  trig_page_i,
  input  logic [7:0]  src_rdata_i,
  output logic        busy_o,
  output logic [15:0] src_addr_o,
  output logic        src_rd_o,
  output logic        wr_o,
  output logic [15:0] wr_addr_o,
  output logic [7:0]  wr_data_o
);

  localparam int          IW       = (DMA_LEN > 1) ? $clog2(DMA_LEN) : 1;
  localparam logic [3:0]  PH_LAST  = 4'(DMA_CYCLES_PER_BYTE - 1);
  localparam bit          LIVE_WR  = (DMA_CYCLES_PER_BYTE == 2);
  localparam logic [3:0]  PH_WR    = LIVE_WR ? 4'd1 : 4'd2;
  localparam logic [IW-1:0] IDX_LAST = IW'(DMA_LEN - 1);

  dma_state_t      state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [3:0]      ph_q, ph_d;
  logic [7:0]      page_q, page_d;
  logic [7:0]      data_q, data_d;
  logic            xfer_s;

  // State, byte index, phase, source page and captured byte.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= DMA_IDLE;
      idx_q   <= '0;
      ph_q    <= 4'd0;
      page_q  <= 8'h00;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ph_q    <= ph_d;
      page_q  <= page_d;
      data_q  <= data_d;
    end
  end

  // Next state; a trigger overrides whatever the sequencer would do this cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ph_d    = ph_q;
    page_d  = page_q;
    data_d  = data_q;
    if (trig_i) begin
      state_d = DMA_START;
      idx_d   = '0;
      ph_d    = 4'd0;
      page_d  = trig_page_i;
    end else begin
      case (state_q)
        DMA_IDLE: begin
          state_d = DMA_IDLE;
        end
        DMA_START: begin
          if (ph_q == PH_LAST) begin
            state_d = DMA_XFER;
            ph_d    = 4'd0;
          end else begin
            ph_d = ph_q + 4'd1;
          end
        end
        DMA_XFER: begin
          if (ph_q == 4'd1) begin
            data_d = src_rdata_i;
          end else begin
            data_d = data_q;
          end
          if (ph_q == PH_LAST) begin
            ph_d = 4'd0;
            if (idx_q == IDX_LAST) begin
              state_d = DMA_IDLE;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            ph_d = ph_q + 4'd1;
          end
        end
        default: begin
          state_d = DMA_IDLE;
          idx_d   = '0;
          ph_d    = 4'd0;
        end
      endcase
    end
  end

  assign xfer_s     = (state_q == DMA_XFER);
  assign busy_o     = (state_q != DMA_IDLE);
  assign src_rd_o   = xfer_s && (ph_q == 4'd0);
  assign src_addr_o = src_rd_o ? ({page_q, 8'h00} + 16'(idx_q)) : 16'h0000;
  assign wr_o       = xfer_s && (ph_q == PH_WR);
  assign wr_addr_o  = wr_o ? (OAM_BASE + 16'(idx_q)) : 16'h0000;
  // With two clocks per byte there is no capture slot, so the live source data is written.
  assign wr_data_o  = wr_o ? (LIVE_WR ? src_rdata_i : data_q) : 8'h00;

endmodule

// File: rtl/oam_dma_arbiter.sv
// Video-memory port arbiter: DMA write > PPU read > CPU access, DMA-busy blocking
// and read-data steering. Optional PPU-mode CPU locks under `PPU_ACCESS_LOCK_EN.
module oam_dma_arbiter
  import ppu_pkg::*;
#(
  parameter int unsigned DMA_CYCLES_PER_BYTE = 4,
  parameter int unsigned DMA_LEN             = 160
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] cpu_addr_i,
  input  logic        cpu_rd_i,
  input  logic        cpu_wr_i,
  input  logic [7:0]  cpu_wdata_i,
  output logic [7:0]  cpu_rdata_o,
  input  logic [1:0]  ppu_mode_i,
  input  logic        ppu_rd_i,
  input  logic [15:0] ppu_addr_i,
  output logic [7:0]  ppu_rdata_o,
  output logic [15:0] vid_addr_o,
  output logic        vid_rd_o,
  output logic        vid_wr_o,
  output logic [7:0]  vid_wdata_o,
  input  logic [7:0]  vid_rdata_i,
  output logic [15:0] dma_src_addr_o,
  output logic        dma_src_rd_o,
  input  logic [7:0]  dma_src_rdata_i,
  output logic        dma_busy_o
);

  PPU_STATES_t mode_s;
  logic        trig_s, dma_busy_s, dma_wr_s;
  logic [15:0] dma_wr_addr_s;
  logic [7:0]  dma_wr_data_s;
  logic        cpu_oam_s, cpu_vram_s, cpu_lock_s, cpu_go_s, ppu_go_s;
  logic        rd_pend_q, rd_pend_d;
  logic        owner_q, owner_d;   // 1 = PPU issued the outstanding read, 0 = CPU

  assign mode_s = PPU_STATES_t'(ppu_mode_i);
  assign trig_s = cpu_wr_i && (cpu_addr_i == DMA_REG_ADDR);

  oam_dma_engine #(
    .DMA_CYCLES_PER_BYTE(DMA_CYCLES_PER_BYTE),
    .DMA_LEN            (DMA_LEN)
  ) u_engine (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .trig_i     (trig_s),
    .trig_page_i(cpu_wdata_i),
    .src_rdata_i(dma_src_rdata_i),
    .busy_o     (dma_busy_s),
    .src_addr_o (dma_src_addr_o),
    .src_rd_o   (dma_src_rd_o),
    .wr_o       (dma_wr_s),
    .wr_addr_o  (dma_wr_addr_s),
    .wr_data_o  (dma_wr_data_s)
  );

  assign dma_busy_o = dma_busy_s;
  assign cpu_oam_s  = is_oam(cpu_addr_i);
  assign cpu_vram_s = is_vram(cpu_addr_i);

`ifdef PPU_ACCESS_LOCK_EN
  assign cpu_lock_s = (cpu_oam_s && ((mode_s == PPU_SCAN) || (mode_s == PPU_DRAW))) ||
                      (cpu_vram_s && (mode_s == PPU_DRAW));
`else
  assign cpu_lock_s = 1'b0 & (mode_s == PPU_DRAW);
`endif

  // OAM is owned by the DMA while it runs, so PPU OAM reads never reach the port then.
  assign ppu_go_s = ppu_rd_i && !dma_wr_s && !(dma_busy_s && is_oam(ppu_addr_i));
  assign cpu_go_s = (cpu_rd_i || cpu_wr_i) && (cpu_oam_s || cpu_vram_s) &&
                    !dma_busy_s && !dma_wr_s && !ppu_rd_i && !cpu_lock_s;

  // Single video port mux in priority order.
  always_comb begin
    vid_addr_o  = 16'h0000;
    vid_rd_o    = 1'b0;
    vid_wr_o    = 1'b0;
    vid_wdata_o = 8'h00;
    if (dma_wr_s) begin
      vid_wr_o    = 1'b1;
      vid_addr_o  = dma_wr_addr_s;
      vid_wdata_o = dma_wr_data_s;
    end else if (ppu_go_s) begin
      vid_rd_o   = 1'b1;
      vid_addr_o = ppu_addr_i;
    end else if (cpu_go_s) begin
      vid_addr_o  = cpu_addr_i;
      vid_wr_o    = cpu_wr_i;
      vid_rd_o    = !cpu_wr_i;
      vid_wdata_o = cpu_wr_i ? cpu_wdata_i : 8'h00;
    end else begin
      vid_rd_o = 1'b0;
    end
  end

  // Next read owner.
  always_comb begin
    rd_pend_d = vid_rd_o;
    owner_d   = owner_q;
    if (ppu_go_s) begin
      owner_d = 1'b1;
    end else if (cpu_go_s) begin
      owner_d = 1'b0;
    end else begin
      owner_d = owner_q;
    end
  end

  // Outstanding-read flag and its owner.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_pend_q <= 1'b0;
      owner_q   <= 1'b0;
    end else begin
      rd_pend_q <= rd_pend_d;
      owner_q   <= owner_d;
    end
  end

  assign cpu_rdata_o = (rd_pend_q && !owner_q) ? vid_rdata_i : 8'hFF;
  assign ppu_rdata_o = (rd_pend_q &&  owner_q) ? vid_rdata_i : 8'hFF;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Self-checking bench for oam_dma_arbiter: timeline model of the DMA plus port
// rules checked every cycle, and directed scenarios with literal expectations.
module tb_oam_dma_arbiter;

  localparam int CPB = 4;
  localparam int LEN = 160;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_addr, ppu_addr;
  logic        cpu_rd, cpu_wr, ppu_rd;
  logic [7:0]  cpu_wdata;
  logic [1:0]  ppu_mode;
  logic [7:0]  cpu_rdata, ppu_rdata, vid_wdata, vid_rdata, dma_src_rdata;
  logic [15:0] vid_addr, dma_src_addr;
  logic        vid_rd, vid_wr, dma_src_rd, dma_busy;

  oam_dma_arbiter #(.DMA_CYCLES_PER_BYTE(CPB), .DMA_LEN(LEN)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cpu_addr_i(cpu_addr), .cpu_rd_i(cpu_rd), .cpu_wr_i(cpu_wr),
    .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata),
    .ppu_mode_i(ppu_mode), .ppu_rd_i(ppu_rd), .ppu_addr_i(ppu_addr),
    .ppu_rdata_o(ppu_rdata),
    .vid_addr_o(vid_addr), .vid_rd_o(vid_rd), .vid_wr_o(vid_wr),
    .vid_wdata_o(vid_wdata), .vid_rdata_i(vid_rdata),
    .dma_src_addr_o(dma_src_addr), .dma_src_rd_o(dma_src_rd),
    .dma_src_rdata_i(dma_src_rdata), .dma_busy_o(dma_busy)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] srcfn(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic in_oam(input logic [15:0] a);
    return (a >= 16'hFE00) && (a <= 16'hFE9F);
  endfunction

  function automatic logic in_vram(input logic [15:0] a);
    return (a >= 16'h8000) && (a <= 16'h9FFF);
  endfunction

  // Video RAM and system-bus source, both with one-cycle read latency.
  logic [7:0] ram [0:65535];
  logic [7:0] ram_q = 8'h00;
  logic [7:0] src_q = 8'h00;
  always @(posedge clk) begin
    if (vid_wr) ram[vid_addr] <= vid_wdata;
    if (vid_rd) ram_q <= ram[vid_addr];
    if (dma_src_rd) src_q <= srcfn(dma_src_addr);
  end
  assign vid_rdata     = ram_q;
  assign dma_src_rdata = src_q;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Model state: DMA is described only by its trigger cycle and source page.
  bit         m_on = 1'b0;
  int         m_trig = 0;
  logic [7:0] m_base = 8'h00;
  bit         m_cpu_pend = 1'b0, m_ppu_pend = 1'b0;
  logic [7:0] m_rd_val = 8'hFF;
  int         busy_total = 0, wr_total = 0, last_fe00 = -1;

  initial forever begin
    logic        e_busy, e_srd, e_vrd, e_vwr, dma_w, lock;
    logic [15:0] e_saddr, e_vaddr, saddr;
    logic [7:0]  e_vwd, e_cpu, e_ppu;
    int          k, bi, ph;
    @(negedge clk);
    e_busy = 1'b0; e_srd = 1'b0; e_saddr = 16'h0000;
    e_vrd = 1'b0; e_vwr = 1'b0; e_vaddr = 16'h0000; e_vwd = 8'h00;
    e_cpu = m_cpu_pend ? m_rd_val : 8'hFF;
    e_ppu = m_ppu_pend ? m_rd_val : 8'hFF;
    m_cpu_pend = 1'b0;
    m_ppu_pend = 1'b0;
    if (!rst_n) begin
      m_on = 1'b0;
      e_cpu = 8'hFF;
      e_ppu = 8'hFF;
    end else begin
      dma_w = 1'b0;
      if (m_on) begin
        k = cyc - m_trig - 1;
        if (k >= (LEN + 1) * CPB) begin
          m_on = 1'b0;
        end else begin
          e_busy = 1'b1;
          if (k >= CPB) begin
            bi = (k - CPB) / CPB;
            ph = (k - CPB) % CPB;
            saddr = {m_base, 8'h00} + 16'(bi);
            if (ph == 0) begin
              e_srd = 1'b1;
              e_saddr = saddr;
            end
            if (ph == ((CPB == 2) ? 1 : 2)) begin
              dma_w = 1'b1;
              e_vwr = 1'b1;
              e_vaddr = 16'hFE00 + 16'(bi);
              e_vwd = srcfn(saddr);
            end
          end
        end
      end
`ifdef PPU_ACCESS_LOCK_EN
      lock = (in_oam(cpu_addr) && ppu_mode >= 2'd2) || (in_vram(cpu_addr) && ppu_mode == 2'd3);
`else
      lock = 1'b0;
`endif
      if (dma_w) begin
        lock = lock;
      end else if (ppu_rd && !(e_busy && in_oam(ppu_addr))) begin
        e_vrd = 1'b1;
        e_vaddr = ppu_addr;
        m_ppu_pend = 1'b1;
        m_rd_val = ram[ppu_addr];
      end else if ((cpu_rd || cpu_wr) && (in_oam(cpu_addr) || in_vram(cpu_addr)) &&
                   !e_busy && !ppu_rd && !lock) begin
        e_vaddr = cpu_addr;
        if (cpu_wr) begin
          e_vwr = 1'b1;
          e_vwd = cpu_wdata;
        end else begin
          e_vrd = 1'b1;
          m_cpu_pend = 1'b1;
          m_rd_val = ram[cpu_addr];
        end
      end
      if (cpu_wr && cpu_addr == 16'hFF46) begin
        m_on = 1'b1;
        m_trig = cyc;
        m_base = cpu_wdata;
      end
    end
    if (dma_busy) busy_total++;
    if (vid_wr) wr_total++;
    if (vid_wr && vid_addr == 16'hFE00) last_fe00 = cyc;
    check("dma_busy", {31'd0, dma_busy}, {31'd0, e_busy});
    check("dma_src", {15'd0, dma_src_rd, dma_src_addr}, {15'd0, e_srd, e_saddr});
    check("vid_port", {6'd0, vid_rd, vid_wr, vid_addr, vid_wdata},
          {6'd0, e_vrd, e_vwr, e_vaddr, e_vwd});
    check("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, e_cpu});
    check("ppu_rdata", {24'd0, ppu_rdata}, {24'd0, e_ppu});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_wdata = d; cpu_wr = 1'b1;
    tick();
    cpu_wr = 1'b0;
  endtask

  task automatic cpu_read_check(input string name, input logic [15:0] a, input logic [7:0] exp);
    cpu_addr = a; cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
    @(negedge clk);
    check(name, {24'd0, cpu_rdata}, {24'd0, exp});
    tick();
  endtask

  task automatic wait_idle(input string name, input int max);
    for (int n = 0; n < max; n++) begin
      if (!dma_busy) break;
      tick();
    end
    check(name, {31'd0, dma_busy}, 32'd0);
  endtask

  int t0, t1, t2, t3, snap_b, snap_w;
  logic [7:0] exp_b;

  initial begin
    rst_n = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; ppu_rd = 1'b0;
    cpu_addr = 16'h0000; cpu_wdata = 8'h00; ppu_addr = 16'h0000; ppu_mode = 2'd0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_busy", {31'd0, dma_busy}, 32'd0);
    check("rst_cpu_rdata", {24'd0, cpu_rdata}, 32'h0000_00FF);
    check("rst_ppu_rdata", {24'd0, ppu_rdata}, 32'h0000_00FF);
    check("rst_vid_addr", {16'd0, vid_addr}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    cpu_write(16'h8000, 8'h11);
    cpu_write(16'h9800, 8'h77);
    cpu_write(16'h8010, 8'h3C);
    cpu_write(16'h9000, 8'h55);

    // PPU in DRAW, no ppu_rd: access allowed only when the lock is compiled out.
    ppu_mode = 2'd3;
`ifdef PPU_ACCESS_LOCK_EN
    exp_b = 8'hFF;
`else
    exp_b = 8'h3C;
`endif
    cpu_read_check("rd_8010_draw", 16'h8010, exp_b);
    cpu_write(16'h9000, 8'hAA);
`ifdef PPU_ACCESS_LOCK_EN
    exp_b = 8'hFF;
`else
    exp_b = 8'h11;
`endif
    cpu_read_check("rd_8000_draw", 16'h8000, exp_b);
    ppu_mode = 2'd0;
`ifdef PPU_ACCESS_LOCK_EN
    exp_b = 8'h55;
`else
    exp_b = 8'hAA;
`endif
    cpu_read_check("rd_9000_after", 16'h9000, exp_b);

    // Same-cycle PPU and CPU reads: PPU wins.
    ppu_rd = 1'b1; ppu_addr = 16'h9800; cpu_rd = 1'b1; cpu_addr = 16'h8000;
    tick();
    ppu_rd = 1'b0; cpu_rd = 1'b0;
    @(negedge clk);
    check("ppu_wins_data", {24'd0, ppu_rdata}, 32'h0000_0077);
    check("cpu_loses_ff", {24'd0, cpu_rdata}, 32'h0000_00FF);
    tick();

    // DMA from C100.
    snap_b = busy_total;
    t0 = cyc;
    cpu_write(16'hFF46, 8'hC1);
    repeat (20) tick();
    ppu_rd = 1'b1; ppu_addr = 16'hFE04;
    tick();
    ppu_rd = 1'b0;
    @(negedge clk);
    check("ppu_oam_busy", {24'd0, ppu_rdata}, 32'h0000_00FF);
    tick();
    cpu_read_check("cpu_vram_busy", 16'h8000, 8'hFF);
    wait_idle("dma1_done", 1000);
    check("dma1_busy_len", busy_total - snap_b, 32'd644);
    check("dma1_first_wr", last_fe00 - t0, 32'd7);
    check("dma1_fe00", {24'd0, ram[16'hFE00]}, 32'h0000_009B);
    check("dma1_fe9f", {24'd0, ram[16'hFE9F]}, 32'h0000_0004);
    cpu_read_check("cpu_rd_fe9f", 16'hFE9F, 8'h04);

    // Retrigger with page 80 on the write cycle of byte 50.
    snap_b = busy_total;
    t1 = cyc;
    cpu_write(16'hFF46, 8'hC1);
    for (int n = 0; n < 400 && cyc < t1 + 207; n++) tick();
    t2 = cyc;
    cpu_write(16'hFF46, 8'h80);
    for (int n = 0; n < 20 && cyc < t2 + 5; n++) tick();
    @(negedge clk);
    check("retrig_src", {15'd0, dma_src_rd, dma_src_addr}, 32'h0001_8000);
    tick();
    wait_idle("dma2_done", 1000);
    check("dma2_busy_len", busy_total - snap_b, 32'd851);
    check("dma2_fe00", {24'd0, ram[16'hFE00]}, 32'h0000_00DA);
    check("dma2_fe9f", {24'd0, ram[16'hFE9F]}, 32'h0000_0045);

    // Reset during byte 20.
    t3 = cyc;
    cpu_write(16'hFF46, 8'hC1);
    for (int n = 0; n < 200 && cyc < t3 + 88; n++) tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_abort_busy", {31'd0, dma_busy}, 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    snap_w = wr_total;
    repeat (200) tick();
    check("no_wr_after_rst", wr_total - snap_w, 32'd0);
    check("rst_fe14", {24'd0, ram[16'hFE14]}, 32'h0000_008F);
    check("rst_fe15", {24'd0, ram[16'hFE15]}, 32'h0000_00CF);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oam_dma_arbiter.md
# oam_dma_arbiter

Owns the single video-memory port (VRAM 8000–9FFF, OAM FE00–FE9F) and shares it between the CPU, the PPU fetch/scan logic and an internal OAM DMA engine triggered by writes to FF46. Applies PPU-mode access locks. Sequences the 160-byte DMA copy from a system-bus source page into OAM. Sits between the CPU memory mux, the PPU and the video RAM instances.

## Interface
- DMA_CYCLES_PER_BYTE, 4, clocks per transferred byte (legal 2..15)
- DMA_LEN, 160, bytes per DMA transfer
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- cpu_addr  in  16  CPU address
- cpu_rd / cpu_wr  in  1  CPU read/write strobes
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  video-region read data, valid the cycle after cpu_rd
- ppu_mode  in  2  PPU mode: 0 HBLANK, 1 VBLANK, 2 SCAN, 3 DRAW
- ppu_rd  in  1  PPU read strobe
- ppu_addr  in  16  PPU address
- ppu_rdata  out  8  PPU read data, valid the cycle after ppu_rd
- vid_addr  out  16  video RAM address
- vid_rd / vid_wr  out  1  video RAM strobes
- vid_wdata  out  8  video RAM write data
- vid_rdata  in  8  video RAM data for the previous cycle's vid_rd
- dma_src_addr  out  16  DMA source address on the system bus
- dma_src_rd  out  1  DMA source read strobe
- dma_src_rdata  in  8  source data, valid the cycle after dma_src_rd
- dma_busy  out  1  DMA in progress; the top level steers the system bus to DMA while high

## Operation
- Video region: 8000–9FFF or FE00–FE9F. CPU accesses outside it are ignored; cpu_rdata = FF.
- DMA trigger: cpu_wr with cpu_addr == FF46 in any state. src_base = {cpu_wdata, 8'h00}, used unmodified.
- DMA FSM states:
  - IDLE: dma_busy = 0.
  - START: one byte-period of delay; dma_busy = 1.
  - XFER: per byte i (0..DMA_LEN-1), phase counter p runs 0..DMA_CYCLES_PER_BYTE-1.
    - p=0: dma_src_rd = 1, dma_src_addr = src_base + i.
    - p=1: capture dma_src_rdata.
    - p=2 (or p=1 when the parameter is 2, using the live input): vid_wr = 1, vid_addr = FE00 + i.
  - After byte DMA_LEN-1 completes, return to IDLE.
- Retrigger while busy: restart at START with the new src_base and i = 0; dma_busy stays high.
- Port priority per cycle: DMA write > PPU read > CPU access. The DMA uses the port only on its write cycle.
- While dma_busy:
  - PPU reads of OAM return FF.
  - CPU video-region reads return FF; CPU video-region writes are dropped.
- A losing CPU read returns FF; a losing CPU write is dropped. No stall signal exists.
- Read return: a 1-bit owner register records who issued vid_rd; vid_rdata is routed to that requester next cycle. The other requester receives FF.

## Timing
- Reset values: all strobes 0, vid_addr/dma_src_addr 0000, vid_wdata 00, cpu_rdata/ppu_rdata FF, dma_busy 0, FSM IDLE, i 0, p 0.
- dma_busy rises the cycle after the trigger write. It stays high for (DMA_LEN+1)*DMA_CYCLES_PER_BYTE cycles: 644 cycles at the defaults.
- First OAM write (FE00): trigger + 1 + DMA_CYCLES_PER_BYTE + 2 cycles.
- Address, strobes and write data are combinational from registered state and inputs; read data has 1-cycle latency.
- Reset asserted mid-DMA: immediate abort, no further writes, outputs return to reset values.
- Simultaneous trigger and DMA write cycle: the current write completes and the restart takes effect the next cycle.
- The last byte at i = DMA_LEN-1 goes to FE9F; the index never wraps.

## Configuration
- PPU_ACCESS_LOCK_EN defined:
  - CPU OAM access is blocked in modes 2 and 3.
  - CPU VRAM access is blocked in mode 3.
  - Blocked reads return FF; blocked writes are dropped, regardless of ppu_rd.
- Undefined: the CPU is blocked only by a same-cycle ppu_rd or DMA write, or by dma_busy.

## Structure
- Shared package ppu_pkg holds:
  - the PPU_STATES_t mode encoding
  - VRAM/OAM base and end constants
  - the FF46 address
  - the DMA FSM enum (DMA_IDLE, DMA_START, DMA_XFER)
- Sub-module oam_dma_engine: FSM, counters, source port and write request. The arbiter top holds priority, locks and the read-owner steering.

## Test plan
- Write FF46 = C1, source returns i^5A -> FE00..FE9F get i^5A; dma_busy high exactly 644 cycles; first vid_wr at trigger+7.
- Retrigger with 80 at byte 50 -> index restarts at 0, source 8000; dma_busy continuous; final FE9F from 809F.
- Lock enabled, ppu_mode=3, CPU writes 9000 = AA -> no vid_wr; CPU read 8000 returns FF.
- Lock disabled, ppu_mode=3, CPU read 8010 with ppu_rd idle -> cpu_rdata = RAM contents next cycle.
- Same-cycle ppu_rd 9800 and CPU read 8000 -> PPU gets data, CPU gets FF; during DMA, PPU read FE04 -> FF.
- rst low at byte 20 -> dma_busy 0 immediately, no OAM writes after release.
